// File: rtl/nibble_pkg.sv
// nibble_pkg -- shared definitions for the nibble CPU control unit.
//   opcode_t  : 4-bit instruction opcodes
//   alu_sel_t : ALU function select encodings
//   state_t   : control FSM state encoding (S_WAIT only with NIBBLE_CTRL_STEP_EN)
//   ctrl_t    : bundle of datapath strobes produced by the decoder
//   is_jump / jump_cond : jump classification helpers
package nibble_pkg;

  typedef enum logic [3:0] {
    OP_JC    = 4'h0, OP_JNC   = 4'h1, OP_CMPI  = 4'h2, OP_CMPM  = 4'h3,
    OP_LIT   = 4'h4, OP_IN    = 4'h5, OP_LD    = 4'h6, OP_ST    = 4'h7,
    OP_JZ    = 4'h8, OP_JNZ   = 4'h9, OP_ADDI  = 4'hA, OP_ADDM  = 4'hB,
    OP_JMP   = 4'hC, OP_OUT   = 4'hD, OP_NANDI = 4'hE, OP_NANDM = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_PASS_A = 3'b000,
    ALU_CMP    = 3'b001,
    ALU_PASS_B = 3'b010,
    ALU_ADD    = 3'b011,
    ALU_NAND   = 3'b100
  } alu_sel_t;

`ifdef NIBBLE_CTRL_STEP_EN
  typedef enum logic [1:0] {S_FETCH = 2'd0, S_EXEC = 2'd1, S_WAIT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_FETCH = 2'd0, S_EXEC = 2'd1} state_t;
`endif

  typedef struct packed {
    logic     fetch;
    logic     pc_inc;
    logic     pc_load;
    alu_sel_t alu_sel;
    logic     acc_we;
    logic     flags_we;
    logic     oe_oprnd;
    logic     mem_oe;
    logic     mem_we;
    logic     in_oe;
    logic     out_we;
    logic     oe_alu;
    logic     phase;
  } ctrl_t;

  function automatic logic is_jump(input opcode_t op);
    return (op == OP_JC) || (op == OP_JNC) || (op == OP_JZ) ||
           (op == OP_JNZ) || (op == OP_JMP);
  endfunction

  // Condition is evaluated on the registered flags, not the live ALU outputs.
  function automatic logic jump_cond(input opcode_t op, input logic c, input logic z);
    case (op)
      OP_JC:   return c;
      OP_JNC:  return !c;
      OP_JZ:   return z;
      OP_JNZ:  return !z;
      OP_JMP:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/nibble_flags.sv
// nibble_flags -- carry/zero flag registers.
//   Clk, Reset : clock, synchronous active-high reset (clears both flags)
//   we         : load c_in/z_in on the rising edge
//   c_in, z_in : ALU carry/zero of the current cycle
//   c_flag, z_flag : registered flags
module nibble_flags (
  input  logic Clk,
  input  logic Reset,
  input  logic we,
  input  logic c_in,
  input  logic z_in,
  output logic c_flag,
  output logic z_flag
);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      c_flag <= 1'b0;
      z_flag <= 1'b0;
    end else if (we) begin
      c_flag <= c_in;
      z_flag <= z_in;
    end
  end

endmodule

// File: rtl/nibble_control_unit.sv
// nibble_control_unit -- two-phase (fetch/execute) control FSM for the nibble CPU.
//   Clk, Reset        : clock, synchronous active-high reset
//   Instr, Oprnd      : fetch register contents (Oprnd is routed by the datapath only)
//   Alu_C, Alu_Z      : live ALU carry/zero
//   Step              : single-step release (only with NIBBLE_CTRL_STEP_EN)
//   Enable_Fetch, Enable_PCounter, Activacion_PCounter_Load : fetch / PC control
//   Alu_Sel, Acc_We, Flags_We, Oe_Oprnd, Mem_Oe, Mem_We, In_Oe, Out_We, Oe_Alu : datapath strobes
//   Phase             : 0 fetch, 1 execute (and step-wait)
//   C_Flag, Z_Flag    : registered flags
// Build option: NIBBLE_CTRL_STEP_EN adds the Step input and an S_WAIT state after
// every execute cycle.
module nibble_control_unit
  import nibble_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] Instr,
  input  logic [3:0] Oprnd,
  input  logic       Alu_C,
  input  logic       Alu_Z,
`ifdef NIBBLE_CTRL_STEP_EN
  input  logic       Step,
`endif
  output logic       Enable_Fetch,
  output logic       Enable_PCounter,
  output logic       Activacion_PCounter_Load,
  output logic [2:0] Alu_Sel,
  output logic       Acc_We,
  output logic       Flags_We,
  output logic       Oe_Oprnd,
  output logic       Mem_Oe,
  output logic       Mem_We,
  output logic       In_Oe,
  output logic       Out_We,
  output logic       Oe_Alu,
  output logic       Phase,
  output logic       C_Flag,
  output logic       Z_Flag
);

  state_t  state;
  opcode_t op;
  ctrl_t   ctl;

  assign op = opcode_t'(Instr);

  // The operand nibble is consumed by the datapath; it is on this port list
  // only so the fetch register interface stays uniform.
  logic unused_oprnd;
  assign unused_oprnd = ^Oprnd;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH: state <= S_EXEC;
`ifdef NIBBLE_CTRL_STEP_EN
        S_EXEC:  state <= S_WAIT;
        S_WAIT:  if (Step) state <= S_FETCH;
`else
        S_EXEC:  state <= S_FETCH;
`endif
        default: state <= S_FETCH;
      endcase
    end
  end

  // Strobes are combinational so that Reset can kill them in the same cycle
  // it is asserted, aborting an in-flight execute without side effects.
  always_comb begin
    ctl = '0;
    if (!Reset) begin
      case (state)
        S_FETCH: begin
          ctl.fetch  = 1'b1;
          ctl.pc_inc = 1'b1;
        end
        S_EXEC: begin
          ctl.phase = 1'b1;
          if (is_jump(op)) begin
            // Not-taken jumps still step past the address byte.
            if (jump_cond(op, C_Flag, Z_Flag)) ctl.pc_load = 1'b1;
            else                               ctl.pc_inc  = 1'b1;
          end else begin
            case (op)
              OP_CMPI:  begin ctl.alu_sel = ALU_CMP;    ctl.oe_oprnd = 1'b1; ctl.flags_we = 1'b1; end
              OP_CMPM:  begin ctl.alu_sel = ALU_CMP;    ctl.mem_oe   = 1'b1; ctl.flags_we = 1'b1; end
              OP_LIT:   begin ctl.alu_sel = ALU_PASS_B; ctl.oe_oprnd = 1'b1; ctl.acc_we   = 1'b1; end
              OP_IN:    begin ctl.alu_sel = ALU_PASS_B; ctl.in_oe    = 1'b1; ctl.acc_we   = 1'b1; end
              OP_LD:    begin ctl.alu_sel = ALU_PASS_B; ctl.mem_oe   = 1'b1; ctl.acc_we   = 1'b1; end
              OP_ST:    begin ctl.alu_sel = ALU_PASS_A; ctl.oe_alu   = 1'b1; ctl.mem_we   = 1'b1; end
              OP_ADDI:  begin ctl.alu_sel = ALU_ADD;    ctl.oe_oprnd = 1'b1; ctl.acc_we = 1'b1; ctl.flags_we = 1'b1; end
              OP_ADDM:  begin ctl.alu_sel = ALU_ADD;    ctl.mem_oe   = 1'b1; ctl.acc_we = 1'b1; ctl.flags_we = 1'b1; end
              OP_OUT:   begin ctl.alu_sel = ALU_PASS_A; ctl.oe_alu   = 1'b1; ctl.out_we   = 1'b1; end
              OP_NANDI: begin ctl.alu_sel = ALU_NAND;   ctl.oe_oprnd = 1'b1; ctl.acc_we = 1'b1; ctl.flags_we = 1'b1; end
              OP_NANDM: begin ctl.alu_sel = ALU_NAND;   ctl.mem_oe   = 1'b1; ctl.acc_we = 1'b1; ctl.flags_we = 1'b1; end
              default:  ;
            endcase
          end
        end
`ifdef NIBBLE_CTRL_STEP_EN
        S_WAIT: ctl.phase = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  nibble_flags u_flags (
    .Clk    (Clk),
    .Reset  (Reset),
    .we     (ctl.flags_we),
    .c_in   (Alu_C),
    .z_in   (Alu_Z),
    .c_flag (C_Flag),
    .z_flag (Z_Flag)
  );

  assign Enable_Fetch             = ctl.fetch;
  assign Enable_PCounter          = ctl.pc_inc;
  assign Activacion_PCounter_Load = ctl.pc_load;
  assign Alu_Sel                  = ctl.alu_sel;
  assign Acc_We                   = ctl.acc_we;
  assign Flags_We                 = ctl.flags_we;
  assign Oe_Oprnd                 = ctl.oe_oprnd;
  assign Mem_Oe                   = ctl.mem_oe;
  assign Mem_We                   = ctl.mem_we;
  assign In_Oe                    = ctl.in_oe;
  assign Out_We                   = ctl.out_we;
  assign Oe_Alu                   = ctl.oe_alu;
  assign Phase                    = ctl.phase;

endmodule

// File: doc/nibble_control_unit.md
NIBBLE_CONTROL_UNIT -- requirements
Module: nibble_control_unit

Interface
REQ-001 Clk  input  1  system clock; all state updates on rising edge.
REQ-002 Reset  input  1  synchronous, active-high reset.
REQ-003 Instr  input  4  opcode held by the fetch register.
REQ-004 Oprnd  input  4  operand nibble held by the fetch register; decoded only for address/immediate routing by the datapath, not by this block.
REQ-005 Alu_C, Alu_Z  input  1 each  carry and zero produced by the ALU in the current cycle.
REQ-006 Enable_Fetch  output  1  loads fetch register from ROM.
REQ-007 Enable_PCounter  output  1  increments program counter.
REQ-008 Activacion_PCounter_Load  output  1  loads PC with 12-bit address {Oprnd, ROM byte}.
REQ-009 Alu_Sel  output  3  000 pass-A, 001 CMP (A-B), 010 pass-B, 011 ADD, 100 NAND.
REQ-010 Acc_We, Flags_We, Oe_Oprnd, Mem_Oe, Mem_We, In_Oe, Out_We, Oe_Alu  output  1 each  datapath strobes.
REQ-011 Phase  output  1  0 = fetch cycle, 1 = execute cycle.
REQ-012 C_Flag, Z_Flag  output  1 each  registered flags.

Function
REQ-013 FSM states S_FETCH, S_EXEC (plus S_WAIT, REQ-028); S_FETCH->S_EXEC unconditionally, S_EXEC->S_FETCH unconditionally.
REQ-014 S_FETCH: Enable_Fetch=1, Enable_PCounter=1, all other strobes 0, Phase=0.
REQ-015 S_EXEC: Phase=1, Enable_Fetch=0; strobes decoded combinationally from Instr, C_Flag, Z_Flag per REQ-016..REQ-022.
REQ-016 Opcodes: 0 JC, 1 JNC, 2 CMPI, 3 CMPM, 4 LIT, 5 IN, 6 LD, 7 ST, 8 JZ, 9 JNZ, A ADDI, B ADDM, C JMP, D OUT, E NANDI, F NANDM.
REQ-017 Jumps (0,1,8,9,C): condition true -> Activacion_PCounter_Load=1, Enable_PCounter=0; false -> Enable_PCounter=1 (skip address byte); JMP always true.
REQ-018 Jump conditions: JC C=1, JNC C=0, JZ Z=1, JNZ Z=0, evaluated on registered flags.
REQ-019 Immediate forms (2,4,A,E): Oe_Oprnd=1, Enable_PCounter=0; memory forms (3,6,B,F): Mem_Oe=1; IN: In_Oe=1.
REQ-020 Acc_We=1 for LIT, IN, LD, ADD*, NAND*; Alu_Sel=010 for LIT/IN/LD, 011 ADD*, 100 NAND*, 001 CMP*.
REQ-021 Flags_We=1 for CMP*, ADD*, NAND*; C_Flag/Z_Flag load Alu_C/Alu_Z on the rising edge ending that S_EXEC cycle; otherwise hold.
REQ-022 ST: Alu_Sel=000, Oe_Alu=1, Mem_We=1; OUT: Alu_Sel=000, Oe_Alu=1, Out_We=1.
REQ-023 At most one of Oe_Oprnd, Mem_Oe, In_Oe, Oe_Alu asserted in any cycle; Enable_PCounter and Activacion_PCounter_Load never both 1.
REQ-024 Non-jump instruction: 2 cycles; all instructions 2 cycles (without REQ-028 stalls).

Reset
REQ-025 Reset=1: next state S_FETCH, C_Flag=0, Z_Flag=0.
REQ-026 While Reset=1 every output strobe forced 0 and Phase=0, regardless of state; reset mid-S_EXEC aborts the instruction with no flag or memory write.
REQ-027 First rising edge with Reset=0 performs a fetch (Enable_Fetch=1 in that cycle).

Configuration
REQ-028 Macro NIBBLE_CTRL_STEP_EN defined: input Step (1 bit) exists; S_EXEC->S_WAIT; S_WAIT holds all strobes 0, Phase=1, exits to S_FETCH on the cycle Step=1; Reset overrides.
REQ-029 Macro undefined: no Step port, no S_WAIT; behaviour exactly REQ-013.

Structure
REQ-030 Shared package nibble_pkg holds opcode constants, Alu_Sel encodings, FSM state encoding.
REQ-031 Flag storage as sub-module nibble_flags (C/Z registers, write enable, sync reset); decode stays in the top.

Verification
REQ-032 Reset held 3 cycles, release -> cycle 1 Enable_Fetch=1, Enable_PCounter=1, Phase=0; cycle 2 Phase=1.
REQ-033 Instr=A, Alu_C=1, Alu_Z=0 in S_EXEC -> Alu_Sel=011, Oe_Oprnd=1, Acc_We=1, Flags_We=1; next cycle C_Flag=1, Z_Flag=0.
REQ-034 C_Flag=1, Instr=0 -> Activacion_PCounter_Load=1, Enable_PCounter=0; C_Flag=0 same Instr -> Enable_PCounter=1, load=0.
REQ-035 Instr=7 -> Oe_Alu=1, Mem_We=1, Alu_Sel=000, Acc_We=0; flags unchanged.
REQ-036 Reset asserted during S_EXEC of Instr=2 -> all strobes 0 that cycle, flags 0 after edge, next state S_FETCH.
REQ-037 NIBBLE_CTRL_STEP_EN, Step=0 for 10 cycles after EXEC -> no Enable_Fetch; Step=1 one cycle -> Enable_Fetch=1 on following cycle.
